// File: rtl/adpll_pkg.sv
// Shared types and helpers for the ADPLL power-up/lock sequencer.
// Holds the FSM state encoding and the saturating phase-error magnitude.
package adpll_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PWRUP = 3'd1,
      PVT   = 3'd2,
      ACQ   = 3'd3,
      TRK   = 3'd4,
      LOCK  = 3'd5
   } state_t;

   // Magnitudes are carried at 32 bits, so phase-error widths up to 31 are supported.
   localparam int unsigned ABS_W = 32;

   // |v| for a w-bit signed value that has been sign-extended to ABS_W.
   // The most negative w-bit code saturates to 2^(w-1)-1 instead of wrapping.
   function automatic logic [ABS_W-1:0] abs_sat(input logic signed [ABS_W-1:0] v,
                                                input int unsigned w);
      logic signed [ABS_W-1:0] lim;
      lim = $signed((32'd1 << (w - 1)) - 32'd1);
      if (v < -lim)
         return $unsigned(lim);
      else if (v < 0)
         return $unsigned(-v);
      else
         return $unsigned(v);
   endfunction

endpackage

// File: rtl/adpll_lock_seq_if.sv
// Control/status bundle between the loop filter, the sequencer and the DCO/TDC.
// master drives enable and phase error; slave is the sequencer itself.
interface adpll_lock_seq_if #(
   parameter int unsigned PE_W  = 16,
   parameter int unsigned CNT_W = 16
) ();

   logic                    en;
   logic signed [PE_W-1:0]  phase_err;
   logic                    dco_pd;
   logic                    tdc_pd;
   logic                    pvt_en;
   logic                    acq_en;
   logic                    trk_en;
   logic                    channel_lock;
   logic                    lock_fail;
   logic [CNT_W-1:0]        settle_cyc;
   logic [2:0]              state;

   modport master (
      output en, phase_err,
      input  dco_pd, tdc_pd, pvt_en, acq_en, trk_en,
             channel_lock, lock_fail, settle_cyc, state
   );

   modport slave (
      input  en, phase_err,
      output dco_pd, tdc_pd, pvt_en, acq_en, trk_en,
             channel_lock, lock_fail, settle_cyc, state
   );

endinterface

// File: rtl/adpll_win_det.sv
// Phase-error window detector: saturating |pe|, inclusive threshold test,
// and consecutive in-window / out-of-window run counters.
module adpll_win_det
   import adpll_pkg::*;
#(
   parameter int unsigned PE_W       = 16,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned WIN_CNT    = 32,
   parameter int unsigned UNLOCK_CNT = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic signed [PE_W-1:0] phase_err,
   input  logic [ABS_W-1:0]       thr,
   output logic                   in_win,
   output logic                   win_done,
   output logic                   out_done
);

   logic signed [ABS_W-1:0] pe_ext;
   logic [ABS_W-1:0]        abs_pe;
   logic [CNT_W-1:0]        in_cnt;
   logic [CNT_W-1:0]        out_cnt;

   assign pe_ext = ABS_W'(phase_err);
   assign abs_pe = abs_sat(pe_ext, PE_W);
   assign in_win = (abs_pe <= thr);

   // done fires on the sample that completes the run, so the FSM moves that edge
   assign win_done = in_win  && (in_cnt  == CNT_W'(WIN_CNT - 1));
   assign out_done = !in_win && (out_cnt == CNT_W'(UNLOCK_CNT - 1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         in_cnt  <= '0;
         out_cnt <= '0;
      end else if (in_win) begin
         out_cnt <= '0;
         if (in_cnt != CNT_W'(WIN_CNT))
            in_cnt <= in_cnt + 1'b1;
      end else begin
         in_cnt <= '0;
         if (out_cnt != CNT_W'(UNLOCK_CNT))
            out_cnt <= out_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/adpll_lock_seq.sv
// ADPLL power-up and lock sequencer: releases DCO/TDC power-down, steps the
// PVT/ACQ/TRK banks on phase-error windows, declares/drops lock, times settling.
module adpll_lock_seq
   import adpll_pkg::*;
#(
   parameter int unsigned PE_W       = 16,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned PU_CYCLES  = 32,
   parameter int unsigned PVT_THR    = 64,
   parameter int unsigned ACQ_THR    = 16,
   parameter int unsigned TRK_THR    = 4,
   parameter int unsigned WIN_CNT    = 32,
   parameter int unsigned UNLOCK_CNT = 8,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic            clk,
   input  logic            rst,
   adpll_lock_seq_if.slave bus
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] dwell_q;
   logic [CNT_W-1:0] settle_q;
   logic             locked_once_q;
   logic             lock_fail_q;
   logic             en_q;
   logic             en_rise;
   logic             fail_blk;
   logic             pu_done;
   logic             tmo_hit;
   logic             timeout;
   logic             st_chg;
   logic [ABS_W-1:0] thr;
   logic             in_win, win_done, out_done;

   assign en_rise  = bus.en && !en_q;
   // an en rising edge clears lock_fail and is allowed to restart in the same cycle
   assign fail_blk = lock_fail_q && !en_rise;
   assign pu_done  = (dwell_q == CNT_W'(PU_CYCLES - 1));
   assign tmo_hit  = (dwell_q == CNT_W'(TIMEOUT - 1));
   assign st_chg   = (state_d != state_q);

   always_comb begin
      case (state_q)
         PVT:     thr = ABS_W'(PVT_THR);
         ACQ:     thr = ABS_W'(ACQ_THR);
         default: thr = ABS_W'(TRK_THR);
      endcase
   end

   adpll_win_det #(
      .PE_W       (PE_W),
      .CNT_W      (CNT_W),
      .WIN_CNT    (WIN_CNT),
      .UNLOCK_CNT (UNLOCK_CNT)
   ) u_win (
      .clk       (clk),
      .rst       (rst),
      .clr       (st_chg),
      .phase_err (bus.phase_err),
      .thr       (thr),
      .in_win    (in_win),
      .win_done  (win_done),
      .out_done  (out_done)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next state: en=0 dominates, then advance, then timeout
   always_comb begin
      state_d = state_q;
      timeout = 1'b0;
      if (!bus.en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:  if (!fail_blk) state_d = PWRUP;
            PWRUP: if (pu_done)   state_d = PVT;
            PVT, ACQ, TRK: begin
               if (win_done) begin
                  state_d = (state_q == PVT) ? ACQ : (state_q == ACQ) ? TRK : LOCK;
               end else if (tmo_hit) begin
                  state_d = IDLE;
                  timeout = 1'b1;
               end
            end
            LOCK:    if (out_done) state_d = ACQ;
            default: state_d = IDLE;
         endcase
      end
   end

   // outputs decoded from registered state
   always_comb begin
      bus.dco_pd       = 1'b0;
      bus.tdc_pd       = 1'b0;
      bus.pvt_en       = 1'b0;
      bus.acq_en       = 1'b0;
      bus.trk_en       = 1'b0;
      bus.channel_lock = 1'b0;
      case (state_q)
         PVT:  bus.pvt_en = 1'b1;
         ACQ:  bus.acq_en = 1'b1;
         TRK:  bus.trk_en = 1'b1;
         LOCK: begin
            bus.trk_en       = 1'b1;
            bus.channel_lock = 1'b1;
         end
         PWRUP: ;
         default: begin
            bus.dco_pd = 1'b1;
            bus.tdc_pd = 1'b1;
         end
      endcase
   end

   assign bus.lock_fail  = lock_fail_q;
   assign bus.settle_cyc = settle_q;
   assign bus.state      = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         en_q        <= 1'b0;
         lock_fail_q <= 1'b0;
      end else begin
         en_q <= bus.en;
         if (timeout)      lock_fail_q <= 1'b1;
         else if (en_rise) lock_fail_q <= 1'b0;
      end
   end

   // dwell restarts on every state change; saturates so LOCK/IDLE can sit forever
   always_ff @(posedge clk) begin
      if (rst || st_chg)
         dwell_q <= '0;
      else if (dwell_q != '1)
         dwell_q <= dwell_q + 1'b1;
   end

   // settle time runs from PWRUP entry until first LOCK entry, then holds
   always_ff @(posedge clk) begin
      if (rst) begin
         settle_q      <= '0;
         locked_once_q <= 1'b0;
      end else if (state_q == IDLE && state_d == PWRUP) begin
         settle_q      <= '0;
         locked_once_q <= 1'b0;
      end else begin
         if (!locked_once_q && state_q inside {PWRUP, PVT, ACQ, TRK} && settle_q != '1)
            settle_q <= settle_q + 1'b1;
         if (state_d == LOCK)
            locked_once_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_adpll_lock_seq.sv
// Directed bench for adpll_lock_seq: each step queues its expected snapshot,
// advances the clock, then pops and compares against the DUT outputs.
module tb_adpll_lock_seq;
   import adpll_pkg::*;

   localparam logic [6:0] FL_IDLE = 7'b1100000;
   localparam logic [6:0] FL_PU   = 7'b0000000;
   localparam logic [6:0] FL_PVT  = 7'b0010000;
   localparam logic [6:0] FL_ACQ  = 7'b0001000;
   localparam logic [6:0] FL_TRK  = 7'b0000100;
   localparam logic [6:0] FL_LOCK = 7'b0000110;
   localparam logic [6:0] FL_FAIL = 7'b1100001;

   typedef struct {
      string       tag;
      logic [2:0]  st;
      logic [6:0]  fl;
      logic [15:0] sc;
      bit          use_sc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   adpll_lock_seq_if #(.PE_W(16), .CNT_W(16)) bus ();

   adpll_lock_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic go(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_front();
      exp_t       e;
      logic [6:0] fl_o;
      checks++;
      assert (sbq.size() != 0) else begin
         errors++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end
      if (sbq.size() != 0) begin
         e    = sbq.pop_front();
         fl_o = {bus.dco_pd, bus.tdc_pd, bus.pvt_en, bus.acq_en,
                 bus.trk_en, bus.channel_lock, bus.lock_fail};
         checks++;
         assert (bus.state === e.st) else begin
            errors++;
            $error("FAIL %s state observed=%0d expected=%0d", e.tag, bus.state, e.st);
         end
         checks++;
         assert (fl_o === e.fl) else begin
            errors++;
            $error("FAIL %s flags observed=%b expected=%b", e.tag, fl_o, e.fl);
         end
         if (e.use_sc) begin
            checks++;
            assert (bus.settle_cyc === e.sc) else begin
               errors++;
               $error("FAIL %s settle observed=%0d expected=%0d", e.tag, bus.settle_cyc, e.sc);
            end
         end
      end
   endtask

   // queue the expectation, run n cycles, then compare; sc<0 means don't-care
   task automatic step(input string tag, input int n, input logic [2:0] st,
                       input logic [6:0] fl, input int sc);
      exp_t e;
      e.tag    = tag;
      e.st     = st;
      e.fl     = fl;
      e.sc     = 16'(sc);
      e.use_sc = (sc >= 0);
      sbq.push_back(e);
      go(n);
      check_front();
   endtask

   initial begin
      rst           = 1'b1;
      bus.en        = 1'b0;
      bus.phase_err = '0;
      step("reset", 2, IDLE, FL_IDLE, 0);

      // clean lock with zero phase error
      rst    = 1'b0;
      bus.en = 1'b1;
      step("pwrup_entry", 1,  PWRUP, FL_PU,   0);
      step("pwrup_hold",  31, PWRUP, FL_PU,   31);
      step("pvt_entry",   1,  PVT,   FL_PVT,  32);
      step("acq_entry",   32, ACQ,   FL_ACQ,  64);
      step("trk_entry",   32, TRK,   FL_TRK,  96);
      step("trk_hold",    31, TRK,   FL_TRK,  127);
      step("lock_entry",  1,  LOCK,  FL_LOCK, 128);
      step("lock_hold",   5,  LOCK,  FL_LOCK, 128);

      // unlock: 7 bad samples hold lock, 8 drop it
      bus.phase_err = 16'sd5;
      step("unlock_7", 7, LOCK, FL_LOCK, 128);
      bus.phase_err = 16'sd0;
      step("unlock_rst", 1, LOCK, FL_LOCK, 128);
      bus.phase_err = 16'sd5;
      step("unlock_8", 8, ACQ, FL_ACQ, 128);

      // ACQ window: inclusive 16, glitch of 17 on cycle 31 restarts the run
      bus.phase_err = 16'sd16;
      go(30);
      bus.phase_err = 16'sd17;
      step("acq_glitch", 1, ACQ, FL_ACQ, 128);
      bus.phase_err = 16'sd16;
      step("acq_restart", 31, ACQ, FL_ACQ, 128);
      step("acq_advance", 1,  TRK, FL_TRK, 128);

      // most negative code must be out of the TRK window
      bus.phase_err = 16'sh8000;
      step("trk_minneg", 40, TRK, FL_TRK, 128);
      bus.phase_err = 16'sd4;
      step("trk_thr_hold", 31, TRK,  FL_TRK,  128);
      step("relock",       1,  LOCK, FL_LOCK, 128);

      // rst mid-LOCK
      rst = 1'b1;
      step("rst_in_lock", 1, IDLE, FL_IDLE, 0);

      // timeout in PVT
      rst           = 1'b0;
      bus.phase_err = 16'sd100;
      step("to_pwrup", 1,    PWRUP, FL_PU,   0);
      step("to_pvt",   32,   PVT,   FL_PVT,  32);
      step("to_hold",  1023, PVT,   FL_PVT,  1055);
      step("to_fail",  1,    IDLE,  FL_FAIL, 1056);
      step("to_stay",  20,   IDLE,  FL_FAIL, 1056);
      bus.en = 1'b0;
      step("to_en_lo", 1, IDLE, FL_FAIL, 1056);
      bus.en        = 1'b1;
      bus.phase_err = 16'sd0;
      step("to_restart", 1, PWRUP, FL_PU, 0);

      // abort from TRK by dropping en
      step("ab_trk", 96, TRK, FL_TRK, 96);
      go(10);
      bus.en = 1'b0;
      step("ab_idle", 1, IDLE, FL_IDLE, 107);
      step("ab_hold", 3, IDLE, FL_IDLE, 107);

      // relock again then reset from LOCK
      bus.en = 1'b1;
      step("re_pwrup", 1,   PWRUP, FL_PU,   0);
      step("re_lock",  128, LOCK,  FL_LOCK, 128);
      rst = 1'b1;
      step("rst_lock2", 1, IDLE, FL_IDLE, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
